// File: rtl/mmc1x_core.sv
// MMC1-family mapper core: serial-load register file, PRG/CHR/WRAM bank
// generation, mirroring and a save-state access port.
module mmc1x_core #(
    parameter int VARIANT       = 1,
    parameter int OUTER         = 0,
    parameter int CONSEC_FILTER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_d7,
    input  logic        cpu_d0,
    input  logic        cpu_rw,
    input  logic        cpu_m2,
    input  logic [2:0]  ppu_addr,
    output logic [4:0]  prg_addr,
    output logic [4:0]  chr_addr,
    output logic [1:0]  wram_bank,
    output logic        wram_ce,
    output logic        prg_ce_n,
    output logic        ciram_a10,
    input  logic [2:0]  sst_addr,
    input  logic        sst_we,
    input  logic [7:0]  sst_di,
    output logic [7:0]  sst_do
);
    localparam logic FILT = (CONSEC_FILTER != 0);

    logic [4:0] ctrl_q, ctrl_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;
    logic [3:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_wr_q, last_wr_d;
    logic       m2_prev_q;
    logic       m2_fall, strobe, accept;
    logic [4:0] chr_sel;
    logic [3:0] prg_lo;
    logic       unused_addr;

    assign unused_addr = ^cpu_addr[12:0];

    assign m2_fall = m2_prev_q & ~cpu_m2;
    assign strobe  = m2_fall & ~cpu_rw & cpu_addr[15];
    assign accept  = strobe & ~(FILT & last_wr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= 5'h0C;
            chr0_q    <= 5'h00;
            chr1_q    <= 5'h00;
            prg_q     <= 5'h00;
            sr_q      <= 4'h0;
            cnt_q     <= 3'd0;
            last_wr_q <= 1'b0;
            m2_prev_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            m2_prev_q <= cpu_m2;
        end
    end

    // A save-state write owns the cycle: any coincident CPU strobe is dropped.
    always_comb begin
        ctrl_d    = ctrl_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        if (sst_we) begin
            case (sst_addr)
                3'd0:    ctrl_d = sst_di[4:0];
                3'd1:    chr0_d = sst_di[4:0];
                3'd2:    chr1_d = sst_di[4:0];
                3'd3:    prg_d  = sst_di[4:0];
                3'd4:    {last_wr_d, cnt_d, sr_d} = sst_di;
                default: ;
            endcase
        end else begin
            if (m2_fall) begin
                last_wr_d = strobe;
            end
            if (accept) begin
                if (cpu_d7) begin
                    sr_d        = 4'h0;
                    cnt_d       = 3'd0;
                    ctrl_d[3:2] = 2'b11;
                end else if (!cnt_q[2]) begin
                    sr_d  = {cpu_d0, sr_q[3:1]};
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    case (cpu_addr[14:13])
                        2'd0:    ctrl_d = {cpu_d0, sr_q};
                        2'd1:    chr0_d = {cpu_d0, sr_q};
                        2'd2:    chr1_d = {cpu_d0, sr_q};
                        default: prg_d  = {cpu_d0, sr_q};
                    endcase
                    sr_d  = 4'h0;
                    cnt_d = 3'd0;
                end
            end
        end
    end

    always_comb begin
        chr_sel = chr0_q;
        if (ctrl_q[4] && ppu_addr[2]) begin
            chr_sel = chr1_q;
        end
        case (ctrl_q[1:0])
            2'd0:    ciram_a10 = 1'b0;
            2'd1:    ciram_a10 = 1'b1;
            2'd2:    ciram_a10 = ppu_addr[0];
            default: ciram_a10 = ppu_addr[1];
        endcase
        case (ctrl_q[3:2])
            2'd2:    prg_lo = cpu_addr[14] ? prg_q[3:0] : 4'h0;
            2'd3:    prg_lo = cpu_addr[14] ? 4'hF : prg_q[3:0];
            default: prg_lo = {prg_q[3:1], cpu_addr[14]};
        endcase
        prg_addr  = {(OUTER >= 1) ? chr_sel[4] : 1'b0, prg_lo};
        chr_addr  = ctrl_q[4] ? chr_sel : {chr0_q[4:1], ppu_addr[2]};
        wram_bank = (OUTER == 2) ? chr_sel[3:2] : 2'b00;
        wram_ce   = (cpu_addr[15:13] == 3'b011) && !((VARIANT == 1) && prg_q[4]);
        prg_ce_n  = ~cpu_addr[15];
    end

    always_comb begin
        case (sst_addr)
            3'd0:    sst_do = {3'b000, ctrl_q};
            3'd1:    sst_do = {3'b000, chr0_q};
            3'd2:    sst_do = {3'b000, chr1_q};
            3'd3:    sst_do = {3'b000, prg_q};
            3'd4:    sst_do = {last_wr_q, cnt_q, sr_q};
            default: sst_do = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_mmc1x_core.sv
// Bench for mmc1x_core: two instances (SXROM/MMC1B/filtered and
// SUROM/MMC1A/unfiltered) checked by vector table, directed sequences and a model.
module tb_mmc1x_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_d7, cpu_d0, cpu_rw, cpu_m2;
    logic [2:0]  ppu_addr;
    logic [2:0]  sst_addr;
    logic        sst_we;
    logic [7:0]  sst_di;

    logic [1:0][4:0] prg_o, chr_o;
    logic [1:0][1:0] wb_o;
    logic [1:0]      wce_o, pce_o, mir_o;
    logic [1:0][7:0] sst_o;

    always #5 clk = ~clk;

    mmc1x_core #(.VARIANT(1), .OUTER(2), .CONSEC_FILTER(1)) u0 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
        .cpu_rw(cpu_rw), .cpu_m2(cpu_m2), .ppu_addr(ppu_addr),
        .prg_addr(prg_o[0]), .chr_addr(chr_o[0]), .wram_bank(wb_o[0]), .wram_ce(wce_o[0]),
        .prg_ce_n(pce_o[0]), .ciram_a10(mir_o[0]),
        .sst_addr(sst_addr), .sst_we(sst_we), .sst_di(sst_di), .sst_do(sst_o[0]));

    mmc1x_core #(.VARIANT(0), .OUTER(1), .CONSEC_FILTER(0)) u1 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
        .cpu_rw(cpu_rw), .cpu_m2(cpu_m2), .ppu_addr(ppu_addr),
        .prg_addr(prg_o[1]), .chr_addr(chr_o[1]), .wram_bank(wb_o[1]), .wram_ce(wce_o[1]),
        .prg_ce_n(pce_o[1]), .ciram_a10(mir_o[1]),
        .sst_addr(sst_addr), .sst_we(sst_we), .sst_di(sst_di), .sst_do(sst_o[1]));

    localparam int P_VAR  [2] = '{1, 0};
    localparam int P_OUT  [2] = '{2, 1};
    localparam int P_FILT [2] = '{1, 0};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: register values plus the bits collected so far.
    logic [4:0] m_reg [2][4];
    int         m_n   [2];
    int         m_val [2];
    bit         m_last[2];

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  d;
        logic [15:0] chk;
        logic [2:0]  ppu;
        logic [4:0]  e_prg;
        logic [4:0]  e_chr;
        logic        e_mir;
        logic [7:0]  e_s0;
        logic [7:0]  e_s1;
    } vec_t;
    vec_t tbl [28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            m_reg[k][0] = 5'h0C;
            m_reg[k][1] = 5'h00;
            m_reg[k][2] = 5'h00;
            m_reg[k][3] = 5'h00;
            m_n[k] = 0;
            m_val[k] = 0;
            m_last[k] = 1'b0;
        end
    endtask

    task automatic mdl_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        bit q;
        q = !rw && a[15];
        for (int k = 0; k < 2; k++) begin
            if (q && !(P_FILT[k] == 1 && m_last[k])) begin
                if (d[7]) begin
                    m_n[k] = 0;
                    m_val[k] = 0;
                    m_reg[k][0] = m_reg[k][0] | 5'h0C;
                end else begin
                    m_val[k] = m_val[k] | (int'(d[0]) << m_n[k]);
                    m_n[k]++;
                    if (m_n[k] == 5) begin
                        m_reg[k][a[14:13]] = 5'(m_val[k]);
                        m_n[k] = 0;
                        m_val[k] = 0;
                    end
                end
            end
            m_last[k] = q;
        end
    endtask

    function automatic logic [4:0] m_sel(int k, logic [2:0] p);
        if (m_reg[k][0][4] && p[2]) return m_reg[k][2];
        return m_reg[k][1];
    endfunction

    function automatic logic [4:0] m_prg(int k, logic [15:0] a);
        int prg, mode, half, bank;
        logic [4:0] s;
        prg  = int'(m_reg[k][3]) & 15;
        mode = (int'(m_reg[k][0]) >> 2) & 3;
        half = int'(a[14]);
        if (mode < 2)       bank = (prg & 14) + half;
        else if (mode == 2) bank = (half == 1) ? prg : 0;
        else                bank = (half == 1) ? 15 : prg;
        s = m_sel(k, ppu_addr);
        if (P_OUT[k] >= 1) bank = bank + 16 * int'(s[4]);
        return 5'(bank);
    endfunction

    function automatic logic [4:0] m_chr(int k, logic [2:0] p);
        if (m_reg[k][0][4]) return m_sel(k, p);
        return 5'((int'(m_reg[k][1]) & 30) + int'(p[2]));
    endfunction

    function automatic logic m_mir(int k, logic [2:0] p);
        case (int'(m_reg[k][0]) & 3)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return p[0];
            default: return p[1];
        endcase
    endfunction

    function automatic logic [1:0] m_wb(int k, logic [2:0] p);
        logic [4:0] s;
        s = m_sel(k, p);
        if (P_OUT[k] == 2) return s[3:2];
        return 2'b00;
    endfunction

    function automatic logic m_wce(int k, logic [15:0] a);
        if ((int'(a) >> 13) != 3) return 1'b0;
        return !(P_VAR[k] == 1 && m_reg[k][3][4]);
    endfunction

    function automatic logic [7:0] m_sst(int k, logic [2:0] sa);
        int sr;
        if (sa < 3'd4) return {3'b000, m_reg[k][sa[1:0]]};
        if (sa == 3'd4) begin
            sr = (m_val[k] << (4 - m_n[k])) & 15;
            return {m_last[k], 3'(m_n[k]), 4'(sr)};
        end
        return 8'hFF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_m2 = 1'b0;
        cpu_rw = 1'b1;
        sst_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a;
        cpu_rw = rw;
        cpu_d7 = d[7];
        cpu_d0 = d[0];
        cpu_m2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cpu_m2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cpu_rw = 1'b1;
        mdl_cycle(a, rw, d);
    endtask

    task automatic load5(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(a, 1'b0, {7'b0, v[i]});
            cpu_cycle(16'h8000, 1'b1, 8'h00);
        end
    endtask

    task automatic sst_write(input logic [2:0] sa, input logic [7:0] v);
        @(negedge clk);
        sst_we = 1'b1;
        sst_addr = sa;
        sst_di = v;
        @(negedge clk);
        sst_we = 1'b0;
    endtask

    task automatic look(input logic [15:0] a, input logic [2:0] p, input logic [2:0] sa);
        @(negedge clk);
        cpu_addr = a;
        ppu_addr = p;
        sst_addr = sa;
        #1;
    endtask

    task automatic check_model(input logic [15:0] a, input logic [2:0] p, input logic [2:0] sa);
        look(a, p, sa);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d prg_addr a=%h", k, a), prg_o[k], m_prg(k, a));
            chk($sformatf("u%0d chr_addr p=%0d", k, p), chr_o[k], m_chr(k, p));
            chk($sformatf("u%0d ciram_a10", k), mir_o[k], m_mir(k, p));
            chk($sformatf("u%0d wram_bank", k), wb_o[k], m_wb(k, p));
            chk($sformatf("u%0d wram_ce a=%h", k, a), wce_o[k], m_wce(k, a));
            chk($sformatf("u%0d prg_ce_n", k), pce_o[k], !a[15]);
            chk($sformatf("u%0d sst_do[%0d]", k, sa), sst_o[k], m_sst(k, sa));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        rst = 1'b1; cpu_addr = 16'h0000; cpu_d7 = 1'b0; cpu_d0 = 1'b0;
        cpu_rw = 1'b1; cpu_m2 = 1'b0; ppu_addr = 3'd0;
        sst_addr = 3'd0; sst_we = 1'b0; sst_di = 8'h00;
        mdl_reset();

        tbl[0]  = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{16'hC000, 1'b1, 8'h00, 16'hC000, 3'd4, 5'h0F, 5'h01, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{16'hE000, 1'b0, 8'h01, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h98, 8'h98};
        tbl[3]  = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h18, 8'h18};
        tbl[4]  = '{16'hE000, 1'b0, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'hA4, 8'hA4};
        tbl[5]  = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h24, 8'h24};
        tbl[6]  = '{16'hE000, 1'b0, 8'h01, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'hBA, 8'hBA};
        tbl[7]  = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h3A, 8'h3A};
        tbl[8]  = '{16'hE000, 1'b0, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'hC5, 8'hC5};
        tbl[9]  = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h00, 5'h00, 1'b0, 8'h45, 8'h45};
        tbl[10] = '{16'hE000, 1'b0, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h80, 8'h80};
        tbl[11] = '{16'hC000, 1'b1, 8'h00, 16'hC000, 3'd0, 5'h0F, 5'h00, 1'b0, 8'h00, 8'h00};
        tbl[12] = '{16'h8000, 1'b0, 8'h01, 16'hC000, 3'd0, 5'h0F, 5'h00, 1'b0, 8'h98, 8'h98};
        tbl[13] = '{16'h8000, 1'b0, 8'h01, 16'hC000, 3'd0, 5'h0F, 5'h00, 1'b0, 8'h98, 8'hAC};
        tbl[14] = '{16'h8000, 1'b0, 8'h01, 16'hC000, 3'd0, 5'h0F, 5'h00, 1'b0, 8'h98, 8'hBE};
        tbl[15] = '{16'h8000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h18, 8'h3E};
        tbl[16] = '{16'h8000, 1'b0, 8'h80, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h80, 8'h80};
        tbl[17] = '{16'hA000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h00, 8'h00};
        tbl[18] = '{16'hA000, 1'b0, 8'h01, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h98, 8'h98};
        tbl[19] = '{16'hA000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h18, 8'h18};
        tbl[20] = '{16'hA000, 1'b0, 8'h01, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'hAC, 8'hAC};
        tbl[21] = '{16'hA000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h2C, 8'h2C};
        tbl[22] = '{16'hA000, 1'b0, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'hB6, 8'hB6};
        tbl[23] = '{16'hA000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h36, 8'h36};
        tbl[24] = '{16'hA000, 1'b0, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'hC3, 8'hC3};
        tbl[25] = '{16'hA000, 1'b1, 8'h00, 16'h8000, 3'd0, 5'h05, 5'h00, 1'b0, 8'h43, 8'h43};
        tbl[26] = '{16'hA000, 1'b0, 8'h01, 16'h8000, 3'd0, 5'h15, 5'h12, 1'b0, 8'h80, 8'h80};
        tbl[27] = '{16'h8000, 1'b1, 8'h00, 16'hC000, 3'd4, 5'h1F, 5'h13, 1'b0, 8'h00, 8'h00};

        do_reset();
        look(16'h8000, 3'd0, 3'd0);
        chk("reset ctrl", sst_o[0], 8'h0C);
        chk("reset prg_addr $8000", prg_o[0], 5'h00);
        chk("reset ciram_a10", mir_o[0], 1'b0);

        for (int i = 0; i < 28; i++) begin
            cpu_cycle(tbl[i].addr, tbl[i].rw, tbl[i].d);
            look(tbl[i].chk, tbl[i].ppu, 3'd4);
            chk($sformatf("vec%0d prg_addr", i), prg_o[0], tbl[i].e_prg);
            chk($sformatf("vec%0d chr_addr", i), chr_o[0], tbl[i].e_chr);
            chk($sformatf("vec%0d ciram_a10", i), mir_o[0], tbl[i].e_mir);
            chk($sformatf("vec%0d u0 sst4", i), sst_o[0], tbl[i].e_s0);
            chk($sformatf("vec%0d u1 sst4", i), sst_o[1], tbl[i].e_s1);
        end

        // Reset in the middle of a load discards the partial value.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(16'hE000, 1'b0, 8'h01);
            cpu_cycle(16'h8000, 1'b1, 8'h00);
        end
        do_reset();
        look(16'h8000, 3'd0, 3'd4);
        chk("midreset u0 sst4", sst_o[0], 8'h00);
        chk("midreset u1 sst4", sst_o[1], 8'h00);
        load5(16'hE000, 5'h0A);
        look(16'h8000, 3'd0, 3'd3);
        chk("midreset u0 prg reg", sst_o[0], 8'h0A);
        chk("midreset u1 prg reg", sst_o[1], 8'h0A);
        chk("midreset prg_addr", prg_o[0], 5'h0A);

        // Outer banking and WRAM disable.
        load5(16'h8000, 5'h10);
        load5(16'hA000, 5'h1C);
        load5(16'hE000, 5'h10);
        look(16'h6000, 3'd0, 3'd0);
        chk("outer u0 prg_addr", prg_o[0], 5'h11);
        chk("outer u0 wram_bank", wb_o[0], 2'd3);
        chk("outer u0 wram_ce", wce_o[0], 1'b0);
        chk("outer u0 chr_addr", chr_o[0], 5'h1C);
        chk("outer u0 prg_ce_n", pce_o[0], 1'b1);
        chk("outer u1 wram_ce", wce_o[1], 1'b1);
        chk("outer u1 wram_bank", wb_o[1], 2'd0);
        chk("outer u1 prg_addr", prg_o[1], 5'h11);
        look(16'h6000, 3'd4, 3'd0);
        chk("outer A12 u0 prg_addr", prg_o[0], 5'h01);
        chk("outer A12 u0 wram_bank", wb_o[0], 2'd0);
        chk("outer A12 u0 chr_addr", chr_o[0], 5'h00);

        // Save-state port and priority over a coincident CPU strobe.
        sst_write(3'd4, 8'h25);
        look(16'h8000, 3'd0, 3'd4);
        chk("sst4 u0 0x25", sst_o[0], 8'h25);
        chk("sst4 u1 0x25", sst_o[1], 8'h25);
        @(negedge clk);
        cpu_addr = 16'hE000; cpu_rw = 1'b0; cpu_d7 = 1'b0; cpu_d0 = 1'b1; cpu_m2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cpu_m2 = 1'b0; sst_we = 1'b1; sst_addr = 3'd1; sst_di = 8'h07;
        @(negedge clk);
        sst_we = 1'b0; cpu_rw = 1'b1;
        @(negedge clk);
        look(16'h8000, 3'd0, 3'd4);
        chk("coincident u0 sst4", sst_o[0], 8'h25);
        chk("coincident u1 sst4", sst_o[1], 8'h25);
        look(16'h8000, 3'd0, 3'd1);
        chk("coincident u0 chr0", sst_o[0], 8'h07);
        chk("coincident u1 chr0", sst_o[1], 8'h07);
        sst_write(3'd4, 8'hA5);
        look(16'h8000, 3'd0, 3'd4);
        chk("sst4 u0 0xA5", sst_o[0], 8'hA5);
        chk("sst4 u1 0xA5", sst_o[1], 8'hA5);
        sst_write(3'd6, 8'h00);
        look(16'h8000, 3'd0, 3'd6);
        chk("sst6 reads FF", sst_o[0], 8'hFF);
        look(16'h8000, 3'd0, 3'd5);
        chk("sst5 reads FF", sst_o[1], 8'hFF);

        // Randomised traffic against the model.
        do_reset();
        check_model(16'hC000, 3'd0, 3'd0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(11) == 0) begin
                d = 8'($urandom);
                a[2:0] = 3'($urandom_range(3));
                sst_write(a[2:0], d);
                m_reg[0][a[1:0]] = d[4:0];
                m_reg[1][a[1:0]] = d[4:0];
            end else begin
                a = 16'($urandom);
                a[15:13] = 3'($urandom_range(7, 3));
                d = 8'($urandom) & 8'h01;
                if ($urandom_range(9) == 0) d = d | 8'h80;
                cpu_cycle(a, ($urandom_range(2) == 0), d);
            end
            a = 16'($urandom);
            a[15:13] = 3'($urandom_range(7, 3));
            check_model(a, 3'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmc1x_core.md
# mmc1x_core

Parametrised MMC1-class mapper core: serial-load register file, PRG/CHR/WRAM bank generation and mirroring for the MMC1 family. It covers plain SxROM, SUROM (512 KB PRG via CHR bit 4) and SXROM (32 KB banked WRAM). Selectable MMC1A/MMC1B WRAM-disable behaviour, consecutive-write filtering and a save-state port are included. It is instantiated by the mapper wrappers in place of the fixed-function core; the wrapper keeps address/CE assembly for memories.

## Interface
- VARIANT, 1, 0 = MMC1A (PRG reg bit 4 ignored), 1 = MMC1B (PRG bit 4 = 1 disables WRAM)
- OUTER, 0, 0 = none, 1 = SUROM (prg_addr[18] from CHR bit 4), 2 = SXROM (SUROM plus wram_bank from CHR bits 3:2)
- CONSEC_FILTER, 1, 1 = ignore a register write in the M2 cycle directly after a register write
- clk  in  1  system clock, faster than M2; all CPU/PPU inputs synchronous to it
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_d7, cpu_d0  in  1 each  CPU data bits 7 and 0
- cpu_rw  in  1  1 = read
- cpu_m2  in  1  CPU M2
- ppu_addr  in  3  PPU A12:A10
- prg_addr  out  5  PRG A18:A14
- chr_addr  out  5  CHR A16:A12
- wram_bank  out  2  WRAM A14:A13
- wram_ce  out  1  WRAM select, $6000-$7FFF and enabled
- prg_ce_n  out  1  !cpu_addr[15]
- ciram_a10  out  1  CIRAM A10
- sst_addr  in  3  save-state register index
- sst_we  in  1  save-state write strobe
- sst_di  in  8  save-state write data
- sst_do  out  8  save-state read data

## Operation
- Write strobe: m2_prev=1 & cpu_m2=0 (m2_prev registered on clk) with cpu_rw=0 and cpu_addr[15]=1.
- Filter state last_wr: on every M2 fall, last_wr <= (strobe qualifies). With CONSEC_FILTER=1, a strobe with last_wr=1 is discarded entirely, including D7 resets. The discarded strobe still keeps last_wr=1.
- Accepted strobe, D7=1:
  - sr and cnt cleared.
  - ctrl[3:2] <= 2'b11; other ctrl bits kept.
- Accepted strobe, D7=0, cnt<4: sr <= {d0, sr[3:1]}, cnt++.
- Accepted strobe, D7=0, cnt=4:
  - value = {d0, sr[3:0]} is written to the target selected by cpu_addr[14:13]: 0 ctrl, 1 chr0, 2 chr1, 3 prg.
  - sr and cnt cleared.
- Mirroring, ctrl[1:0]: 0 → 0; 1 → 1; 2 → ppu_addr[10]; 3 → ppu_addr[11].
- PRG A17:A14, ctrl[3:2]:
  - 0/1: {prg[3:1], cpu_addr[14]}.
  - 2: A14=0 → 0, else prg[3:0].
  - 3: A14=0 → prg[3:0], else 4'hF.
- CHR:
  - ctrl[4]=0: chr_addr = {chr0[4:1], ppu_addr[12]}, and chr_sel = chr0.
  - ctrl[4]=1: chr_sel = ppu_addr[12] ? chr1 : chr0, and chr_addr = chr_sel.
- prg_addr[18]: chr_sel[4] if OUTER≥1, else 0.
- wram_bank: chr_sel[3:2] if OUTER=2, else 0.
- wram_ce: cpu_addr[15:13]==3'b011, qualified by !prg[4] when VARIANT=1.
- Save state, sst_addr → register: 0 ctrl, 1 chr0, 2 chr1, 3 prg, 4 {last_wr, cnt[2:0], sr[3:0]}, 5-7 read 8'hFF. Write addresses 5-7 are ignored.
  - 5-bit registers read with bits 7:5 = 0.
  - sst_we writes at clk.
  - sst_we has priority over a CPU strobe in the same clk; that strobe is dropped and last_wr is not updated.

## Timing
- Reset values: ctrl=5'h0C, chr0=chr1=prg=0, sr=0, cnt=0, last_wr=0, m2_prev=0.
- Resulting outputs at reset: prg_addr = 5'h00 at $8000 and 5'h0F at $C000, chr_addr=0, ciram_a10=0, wram_bank=0, wram_ce per address.
- All bank outputs are combinational from registers and current addresses: zero cycles from an address change.
- A strobe detected in clk cycle N updates registers at the end of N. New banks are visible in N+1, well before the next M2 rise.
- rst mid-sequence (cnt 1..4) discards partial data; the next load starts at cnt=0.
- Holding cpu_m2 low produces a single strobe, since only edges count.
- Reads to $8000+ never affect sr, cnt or last_wr state beyond clearing last_wr on their M2 fall.

## Test plan
- Reset, no writes → read $8000 gives prg_addr=0; read $C000 gives prg_addr=0x0F; ciram_a10=0; chr_addr=0.
- Five writes to $E000 with D0 = 1,0,1,0,0, separated by non-write M2 cycles → prg=5'h05; $8000 gives prg_addr=5, $C000 gives 0x0F.
- Write $8000 D0=1 twice in back-to-back M2 cycles with CONSEC_FILTER=1 → cnt=1 only. With CONSEC_FILTER=0 → cnt=2.
- Three shift writes, then an accepted D7=1 write → cnt=0, ctrl[3:2]=3; a subsequent 5-write load to $A000 of 5'h13 sets chr0=0x13.
- OUTER=2, ctrl=5'h10, chr0=5'h1C: PPU A12=0 gives prg_addr[18]=1 and wram_bank=3; VARIANT=1 with prg=5'h10 gives wram_ce=0 at $6000.
- sst_we to addr 4 with 8'hA5 → last_wr=1, cnt=2, sr=5; readback 8'hA5. sst_we coincident with a CPU strobe → the CPU strobe has no effect.
